// File: rtl/decapsulation.sv
// GMII receive-side frame parser: drops preamble/SFD and the MAC header, streams the payload
// (pad excluded) into the RX buffer and commits or rolls back each frame on its FCS check.
module decapsulation #(
  parameter logic [47:0] local_mac_addr = 48'h072227acdb65,
  parameter bit          PROMISC        = 1'b0,
  parameter logic [7:0]  PREAMBLE_VAL   = 8'h55,
  parameter logic [7:0]  SFD_VAL        = 8'hD5,
  parameter int unsigned MAX_LEN        = 1500
) (
  input  logic        eth_rx_clk,
  input  logic        rst,
  input  logic        eth_rx_en,
  input  logic [7:0]  GMII_rx_d,
  input  logic        GMII_rx_dv,
  input  logic        GMII_rx_er,
  output logic [7:0]  bf_in_data,
  output logic        bf_in_w_en,
  output logic        bf_in_pct_rxed,
  output logic        bf_in_pct_drop,
  output logic [15:0] rx_len,
  output logic [47:0] rx_src_mac,
  output logic [15:0] cnt_good,
  output logic [15:0] cnt_err
);

  localparam logic [15:0] MaxLen      = 16'(MAX_LEN);
  localparam logic [15:0] MinPayload  = 16'd46;
  localparam logic [15:0] MaxPreamble = 16'd7;
  localparam logic [31:0] CrcPoly     = 32'hEDB88320;
  localparam logic [31:0] CrcResidue  = 32'hDEBB20E3;

  typedef enum logic [3:0] {
    StIdle,
    StPreamble,
    StDestMac,
    StSrcMac,
    StLen,
    StPayload,
    StPad,
    StFcs,
    StWaitIdle
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;
  logic [39:0] dest_q, dest_d;
  logic [47:0] src_q, src_d;
  logic [15:0] len_q, len_d;

  logic [7:0]  data_q, data_d;
  logic        w_en_q, w_en_d;
  logic        rxed_q, rxed_d;
  logic        drop_q, drop_d;
  logic [15:0] rx_len_q, rx_len_d;
  logic [47:0] rx_src_q, rx_src_d;
  logic [15:0] good_q, good_d;
  logic [15:0] err_q, err_d;

  logic        in_frame;
  logic        abort;
  logic        dest_ok;
  logic [47:0] dest_full;
  logic [15:0] len_full;
  logic [31:0] crc_nxt;
  logic [15:0] good_inc;
  logic [15:0] err_inc;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign crc_nxt   = crc_byte(crc_q, GMII_rx_d);
  assign dest_full = {dest_q, GMII_rx_d};
  assign dest_ok   = PROMISC || (dest_full == local_mac_addr) || (dest_full == '1);
  assign len_full  = {len_q[7:0], GMII_rx_d};
  assign good_inc  = (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
  assign err_inc   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  always_comb begin
    in_frame = 1'b0;
    case (state_q)
      StDestMac, StSrcMac, StLen, StPayload, StPad, StFcs: in_frame = 1'b1;
      default:                                             in_frame = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    dest_d   = dest_q;
    src_d    = src_q;
    len_d    = len_q;
    data_d   = data_q;
    w_en_d   = 1'b0;
    rxed_d   = 1'b0;
    drop_d   = 1'b0;
    rx_len_d = rx_len_q;
    rx_src_d = rx_src_q;
    good_d   = good_q;
    err_d    = err_q;
    abort    = 1'b0;

    if (in_frame && (!GMII_rx_dv || GMII_rx_er)) begin
      abort = 1'b1;
    end else begin
      if (in_frame) begin
        crc_d = crc_nxt;
      end
      case (state_q)
        StIdle: begin
          if (GMII_rx_dv) begin
            if (eth_rx_en && (GMII_rx_d == PREAMBLE_VAL)) begin
              state_d = StPreamble;
              cnt_d   = 16'd1;
            end else begin
              state_d = StWaitIdle;
            end
          end
        end
        StPreamble: begin
          if (GMII_rx_dv && (GMII_rx_d == PREAMBLE_VAL) && (cnt_q < MaxPreamble)) begin
            cnt_d = cnt_q + 16'd1;
          end else if (GMII_rx_dv && (GMII_rx_d == SFD_VAL)) begin
            state_d = StDestMac;
            cnt_d   = 16'd0;
            crc_d   = 32'hFFFF_FFFF;
          end else begin
            state_d = StWaitIdle;
          end
        end
        StDestMac: begin
          dest_d = dest_full[39:0];
          if (cnt_q == 16'd5) begin
            if (dest_ok) begin
              state_d = StSrcMac;
              cnt_d   = 16'd0;
            end else begin
              abort = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StSrcMac: begin
          src_d = {src_q[39:0], GMII_rx_d};
          if (cnt_q == 16'd5) begin
            state_d = StLen;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StLen: begin
          len_d = len_full;
          if (cnt_q == 16'd1) begin
            if ((len_full == 16'd0) || (len_full > MaxLen)) begin
              abort = 1'b1;
            end else begin
              state_d = StPayload;
              cnt_d   = 16'd0;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StPayload: begin
          w_en_d = 1'b1;
          data_d = GMII_rx_d;
          if (cnt_q == len_q - 16'd1) begin
            state_d = (len_q < MinPayload) ? StPad : StFcs;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StPad: begin
          if (cnt_q == MinPayload - 16'd1 - len_q) begin
            state_d = StFcs;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StFcs: begin
          if (cnt_q == 16'd3) begin
            state_d = StWaitIdle;
            // Running the received FCS through the CRC leaves a fixed residue when intact.
            if (crc_nxt == CrcResidue) begin
              rxed_d   = 1'b1;
              rx_len_d = len_q;
              rx_src_d = src_q;
              good_d   = good_inc;
            end else begin
              drop_d = 1'b1;
              err_d  = err_inc;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        StWaitIdle: begin
          if (!GMII_rx_dv) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (abort) begin
      state_d = StWaitIdle;
      w_en_d  = 1'b0;
      rxed_d  = 1'b0;
      drop_d  = 1'b1;
      err_d   = err_inc;
    end
  end

  always_ff @(posedge eth_rx_clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      crc_q    <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      w_en_q   <= 1'b0;
      rxed_q   <= 1'b0;
      drop_q   <= 1'b0;
      rx_len_q <= '0;
      rx_src_q <= '0;
      good_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      len_q    <= len_d;
      data_q   <= data_d;
      w_en_q   <= w_en_d;
      rxed_q   <= rxed_d;
      drop_q   <= drop_d;
      rx_len_q <= rx_len_d;
      rx_src_q <= rx_src_d;
      good_q   <= good_d;
      err_q    <= err_d;
    end
  end

  assign bf_in_data     = data_q;
  assign bf_in_w_en     = w_en_q;
  assign bf_in_pct_rxed = rxed_q;
  assign bf_in_pct_drop = drop_q;
  assign rx_len         = rx_len_q;
  assign rx_src_mac     = rx_src_q;
  assign cnt_good       = good_q;
  assign cnt_err        = err_q;

endmodule
